// File: rtl/pipeline_pc_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_pc_fetch_if
//  Description : Instruction-memory (icache) request/response bundle between
//                the fetch stage (master) and the icache (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface pipeline_pc_fetch_if;
    logic        ihit;      // iload valid for imemaddr this cycle
    logic [31:0] iload;     // instruction word
    logic        imemREN;   // read enable
    logic [31:0] imemaddr;  // read address

    modport master (
        input  ihit,
        input  iload,
        output imemREN,
        output imemaddr
    );

    modport slave (
        output ihit,
        output iload,
        input  imemREN,
        input  imemaddr
    );
endinterface
`default_nettype wire

// File: rtl/pipeline_pc_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_pc_fetch
//  Description : Fetch-stage front end. Owns the PC, drives the icache
//                request, absorbs miss latency, parks redirects that land
//                mid-miss and stops on HALT until a redirect squashes it.
//  Revision    : 1.0  initial release
// ============================================================================
module pipeline_pc_fetch #(
    parameter logic [31:0] PC_INIT     = 32'h0000_0000,
    parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
    input  wire logic          CLK,
    input  wire logic          nRST,
    pipeline_pc_fetch_if.master imem,
    input  wire logic          i_stall,
    input  wire logic          i_redirect_valid,
    input  wire logic [31:0]   i_redirect_pc,
    output logic      [31:0]   o_instr_out,
    output logic      [31:0]   o_npc_out,
    output logic               o_fetch_valid,
    output logic               o_flush_out
);

    typedef enum logic [0:0] {
        ST_FETCH  = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_pend_valid;
    logic [31:0] r_pend_pc;

    logic [31:0] w_redirect_tgt;
    logic [31:0] w_pc_plus4;
    logic        w_fetching;
    logic        w_fetch_valid;
    logic        w_halt;

    // Targets are word aligned; low bits from the resolver are dropped.
    assign w_redirect_tgt = i_redirect_pc & 32'hFFFF_FFFC;
    assign w_pc_plus4     = r_pc + 32'd4;
    assign w_fetching     = (r_state == ST_FETCH);

    // A hit is only good-path when no older redirect (pending or current)
    // is about to replace the PC.
    assign w_fetch_valid  = w_fetching & imem.ihit & ~r_pend_valid & ~i_redirect_valid;
    assign w_halt         = w_fetch_valid & (imem.iload[31:26] == HALT_OPCODE) & ~i_stall;

    assign imem.imemREN   = w_fetching;
    assign imem.imemaddr  = r_pc;
    assign o_instr_out    = imem.iload;
    assign o_npc_out      = w_pc_plus4;
    assign o_fetch_valid  = w_fetch_valid;
    assign o_flush_out    = i_redirect_valid;

    // PC / pending-redirect / FETCH-HALTED state machine.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state      <= ST_FETCH;
            r_pc         <= PC_INIT;
            r_pend_valid <= 1'b0;
            r_pend_pc    <= 32'h0000_0000;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (imem.ihit) begin
                        if (i_redirect_valid) begin
                            r_pc         <= w_redirect_tgt;
                            r_pend_valid <= 1'b0;
                        end else if (r_pend_valid) begin
                            r_pc         <= r_pend_pc;
                            r_pend_valid <= 1'b0;
                        end else if (i_stall) begin
                            r_pc <= r_pc;
                        end else if (w_halt) begin
                            // PC stays on the HALT so a squash can re-steer cleanly.
                            r_state <= ST_HALTED;
                        end else begin
                            r_pc <= w_pc_plus4;
                        end
                    end else if (i_redirect_valid) begin
                        // Address must stay stable while the miss is outstanding.
                        r_pend_valid <= 1'b1;
                        r_pend_pc    <= w_redirect_tgt;
                    end
                end
                ST_HALTED: begin
                    if (i_redirect_valid) begin
                        r_pc         <= w_redirect_tgt;
                        r_pend_valid <= 1'b0;
                        r_state      <= ST_FETCH;
                    end
                end
                default: r_state <= ST_FETCH;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_pc_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_pc_fetch
//  Description : Self-checking bench for pipeline_pc_fetch: behavioural model
//                with per-cycle compare plus directed literal expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipeline_pc_fetch;

    localparam logic [31:0] C_PC_INIT = 32'h0000_0000;
    localparam logic [31:0] C_NOP     = 32'h0000_0013;
    localparam logic [31:0] C_HALT    = 32'hFC00_0000;

    logic        CLK;
    logic        nRST;
    logic        i_stall;
    logic        i_redirect_valid;
    logic [31:0] i_redirect_pc;
    logic [31:0] o_instr_out;
    logic [31:0] o_npc_out;
    logic        o_fetch_valid;
    logic        o_flush_out;

    int n_cmp  = 0;
    int n_fail = 0;

    pipeline_pc_fetch_if imem ();

    pipeline_pc_fetch #(
        .PC_INIT     (C_PC_INIT),
        .HALT_OPCODE (6'b111111)
    ) dut (
        .CLK              (CLK),
        .nRST             (nRST),
        .imem             (imem.master),
        .i_stall          (i_stall),
        .i_redirect_valid (i_redirect_valid),
        .i_redirect_pc    (i_redirect_pc),
        .o_instr_out      (o_instr_out),
        .o_npc_out        (o_npc_out),
        .o_fetch_valid    (o_fetch_valid),
        .o_flush_out      (o_flush_out)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_pc;
    logic        m_pend;
    logic [31:0] m_pend_pc;
    logic        m_halted;

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            m_pc = C_PC_INIT; m_pend = 1'b0; m_pend_pc = 32'h0; m_halted = 1'b0;
        end else if (m_halted) begin
            if (i_redirect_valid) begin
                m_pc = {i_redirect_pc[31:2], 2'b00};
                m_halted = 1'b0;
            end
        end else if (imem.ihit) begin
            if (i_redirect_valid) begin
                m_pc = {i_redirect_pc[31:2], 2'b00}; m_pend = 1'b0;
            end else if (m_pend) begin
                m_pc = m_pend_pc; m_pend = 1'b0;
            end else if (i_stall) begin
                m_pc = m_pc;
            end else if (imem.iload[31:26] == 6'h3F) begin
                m_halted = 1'b1;
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end else if (i_redirect_valid) begin
            m_pend = 1'b1;
            m_pend_pc = {i_redirect_pc[31:2], 2'b00};
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge CLK) begin
        chk("m_imemREN",  {31'b0, imem.imemREN}, {31'b0, ~m_halted});
        chk("m_imemaddr", imem.imemaddr, m_pc);
        chk("m_npc",      o_npc_out, m_pc + 32'd4);
        chk("m_instr",    o_instr_out, imem.iload);
        chk("m_fvalid",   {31'b0, o_fetch_valid},
            {31'b0, ~m_halted & imem.ihit & ~m_pend & ~i_redirect_valid});
        chk("m_flush",    {31'b0, o_flush_out}, {31'b0, i_redirect_valid});
    end

    // Drive one cycle's inputs just after the edge, then settle past the negedge.
    task automatic cyc(input logic h, input logic [31:0] ld, input logic st,
                       input logic rv, input logic [31:0] rpc);
        @(posedge CLK);
        #1;
        imem.ihit = h; imem.iload = ld; i_stall = st;
        i_redirect_valid = rv; i_redirect_pc = rpc;
        #5;
    endtask

    initial begin
        nRST = 1'b0;
        imem.ihit = 1'b0; imem.iload = C_NOP; i_stall = 1'b0;
        i_redirect_valid = 1'b0; i_redirect_pc = 32'h0;
        #22;
        chk("rst_ren",   {31'b0, imem.imemREN}, 32'd1);
        chk("rst_addr",  imem.imemaddr, 32'h0);
        chk("rst_flush", {31'b0, o_flush_out}, 32'd0);
        nRST = 1'b1;

        // Straight-line hits
        cyc(1, C_NOP, 0, 0, 0);
        chk("t1_addr0", imem.imemaddr, 32'h0); chk("t1_npc0", o_npc_out, 32'h4);
        chk("t1_fv0", {31'b0, o_fetch_valid}, 32'd1);
        cyc(1, C_NOP, 0, 0, 0);
        chk("t1_addr1", imem.imemaddr, 32'h4); chk("t1_npc1", o_npc_out, 32'h8);
        cyc(1, C_NOP, 0, 0, 0);
        chk("t1_addr2", imem.imemaddr, 32'h8); chk("t1_npc2", o_npc_out, 32'hC);
        cyc(1, C_NOP, 0, 0, 0);

        // Miss latency at 0x10
        for (int i = 0; i < 3; i++) begin
            cyc(0, C_NOP, 0, 0, 0);
            chk("t2_miss_addr", imem.imemaddr, 32'h10);
            chk("t2_miss_fv", {31'b0, o_fetch_valid}, 32'd0);
        end
        cyc(1, C_NOP, 0, 0, 0);
        chk("t2_hit_fv", {31'b0, o_fetch_valid}, 32'd1);
        cyc(1, C_NOP, 0, 0, 0);
        chk("t2_next", imem.imemaddr, 32'h14);
        cyc(1, C_NOP, 0, 0, 0);
        cyc(1, C_NOP, 0, 0, 0);

        // Stall at 0x20
        for (int i = 0; i < 2; i++) begin
            cyc(1, C_NOP, 1, 0, 0);
            chk("t3_stall_addr", imem.imemaddr, 32'h20);
            chk("t3_stall_fv", {31'b0, o_fetch_valid}, 32'd1);
        end
        cyc(1, C_NOP, 0, 0, 0);
        chk("t3_release", imem.imemaddr, 32'h20);
        cyc(1, C_NOP, 0, 0, 0);
        chk("t3_adv", imem.imemaddr, 32'h24);
        cyc(1, C_NOP, 0, 0, 0);
        cyc(1, C_NOP, 0, 0, 0);

        // Redirect during a miss at 0x30
        cyc(0, C_NOP, 0, 1, 32'h100);
        chk("t4_flush", {31'b0, o_flush_out}, 32'd1);
        chk("t4_addr1", imem.imemaddr, 32'h30);
        cyc(0, C_NOP, 0, 0, 0);
        chk("t4_addr2", imem.imemaddr, 32'h30);
        cyc(1, C_NOP, 0, 0, 0);
        chk("t4_fv3", {31'b0, o_fetch_valid}, 32'd0);
        cyc(1, C_NOP, 0, 1, 32'h40);
        chk("t4_tgt", imem.imemaddr, 32'h100);

        // HALT at 0x40, squashed by redirect to 0x80
        cyc(1, C_HALT, 0, 0, 0);
        chk("t5_haddr", imem.imemaddr, 32'h40);
        chk("t5_hfv", {31'b0, o_fetch_valid}, 32'd1);
        cyc(1, C_NOP, 1, 0, 0);
        chk("t5_ren", {31'b0, imem.imemREN}, 32'd0);
        chk("t5_addr", imem.imemaddr, 32'h40);
        chk("t5_fv", {31'b0, o_fetch_valid}, 32'd0);
        cyc(1, C_NOP, 0, 1, 32'h80);
        chk("t5_flush", {31'b0, o_flush_out}, 32'd1);
        cyc(1, C_NOP, 0, 0, 0);
        chk("t5_resume_ren", {31'b0, imem.imemREN}, 32'd1);
        chk("t5_resume", imem.imemaddr, 32'h80);

        // Redirect beats stall; target alignment
        cyc(1, C_NOP, 1, 1, 32'h203);
        chk("t6_fv", {31'b0, o_fetch_valid}, 32'd0);
        chk("t6_flush", {31'b0, o_flush_out}, 32'd1);
        cyc(0, C_NOP, 0, 0, 0);
        chk("t6_addr", imem.imemaddr, 32'h200);

        // HALT under stall is not taken
        cyc(1, C_HALT, 1, 0, 0);
        chk("hs_fv", {31'b0, o_fetch_valid}, 32'd1);
        cyc(1, C_NOP, 0, 0, 0);
        chk("hs_ren", {31'b0, imem.imemREN}, 32'd1);
        chk("hs_addr", imem.imemaddr, 32'h200);

        // Later redirect overwrites pending; pending beats stall
        cyc(0, C_NOP, 0, 1, 32'h300);
        chk("pd_addr", imem.imemaddr, 32'h204);
        cyc(0, C_NOP, 0, 1, 32'h400);
        cyc(1, C_NOP, 1, 0, 0);
        chk("pd_fv", {31'b0, o_fetch_valid}, 32'd0);
        cyc(0, C_NOP, 0, 0, 0);
        chk("pd_tgt", imem.imemaddr, 32'h400);

        // Wrap
        cyc(1, C_NOP, 0, 1, 32'hFFFF_FFFF);
        cyc(1, C_NOP, 0, 0, 0);
        chk("wr_addr", imem.imemaddr, 32'hFFFF_FFFC);
        chk("wr_npc", o_npc_out, 32'h0);
        cyc(0, C_NOP, 0, 0, 0);
        chk("wr_zero", imem.imemaddr, 32'h0);

        // Reset while a redirect is pending
        cyc(0, C_NOP, 0, 1, 32'h500);
        #1 nRST = 1'b0;
        #1;
        chk("ar_addr", imem.imemaddr, C_PC_INIT);
        cyc(0, C_NOP, 0, 0, 0);
        nRST = 1'b1;
        cyc(1, C_NOP, 0, 0, 0);
        chk("ar_fv", {31'b0, o_fetch_valid}, 32'd1);
        chk("ar_addr2", imem.imemaddr, 32'h0);
        cyc(1, C_NOP, 0, 0, 0);
        chk("ar_next", imem.imemaddr, 32'h4);

        cyc(0, C_NOP, 0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
